// File: rtl/game_countdown_if.sv
// game_countdown_if: control and status bundle for the seconds countdown.
//   tick_in   - divided timer clock (asynchronous level) into the countdown
//   start     - one-cycle pulse: reload and run
//   pause     - one-cycle pulse: toggle run/pause
//   tick_out  - synchronised one-cycle tick per tick_in rising edge
//   sec_tens  - BCD tens digit
//   sec_ones  - BCD ones digit
//   running   - high while counting
//   time_up   - high once the count has reached 00
// master drives the controls (game logic / bench); slave is the countdown.
interface game_countdown_if;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic       tick_out;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       time_up;

    modport master (
        output tick_in, start, pause,
        input  tick_out, sec_tens, sec_ones, running, time_up
    );

    modport slave (
        input  tick_in, start, pause,
        output tick_out, sec_tens, sec_ones, running, time_up
    );
endinterface

// File: rtl/game_countdown.sv
// game_countdown: two-digit BCD seconds countdown for the coin-catcher round.
// The slow divider clock arrives as data on bus.tick_in, is synchronised into
// the clk_in domain and edge-detected into single-cycle ticks. A
// IDLE/RUN/PAUSE/DONE machine counts START_SEC (legal 1..99) down to 00.
//   clk_in  - system clock, rising edge
//   reset   - asynchronous, active-low
//   bus     - game_countdown_if.slave (controls in, digits/status out)
module game_countdown #(
    parameter int START_SEC = 60
) (
    input logic              clk_in,
    input logic              reset,
    game_countdown_if.slave  bus
);
    localparam logic [3:0] TENS = 4'(START_SEC / 10);
    localparam logic [3:0] ONES = 4'(START_SEC % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state;
    logic       s1, s2, prev, tick_r;
    logic [3:0] tens, ones;
    logic       running_r, time_up_r;

    // Two-flop synchroniser followed by a rising-edge detector.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            prev   <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            s1     <= bus.tick_in;
            s2     <= s1;
            prev   <= s2;
            tick_r <= s2 & ~prev;
        end
    end

    // Priority: start > pause > tick. In RUN a tick coinciding with pause is
    // still counted; a tick that reaches 00 wins over pause and ends the round.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tens      <= TENS;
            ones      <= ONES;
            running_r <= 1'b0;
            time_up_r <= 1'b0;
        end else if (bus.start) begin
            state     <= RUN;
            tens      <= TENS;
            ones      <= ONES;
            running_r <= 1'b1;
            time_up_r <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (tick_r && tens == 4'd0 && ones == 4'd1) begin
                        ones      <= 4'd0;
                        state     <= DONE;
                        running_r <= 1'b0;
                        time_up_r <= 1'b1;
                    end else begin
                        if (tick_r) begin
                            if (ones != 4'd0) begin
                                ones <= ones - 4'd1;
                            end else begin
                                ones <= 4'd9;
                                tens <= tens - 4'd1;
                            end
                        end
                        if (bus.pause) begin
                            state     <= PAUSE;
                            running_r <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.pause) begin
                        state     <= RUN;
                        running_r <= 1'b1;
                    end
                end
                default: ;  // IDLE and DONE wait for start only
            endcase
        end
    end

    assign bus.tick_out = tick_r;
    assign bus.sec_tens = tens;
    assign bus.sec_ones = ones;
    assign bus.running  = running_r;
    assign bus.time_up  = time_up_r;
endmodule

// File: tb/tb_game_countdown.sv
// tb_game_countdown: three countdowns (START_SEC 60, 10, 3) share one
// stimulus stream; tasks check the relevant instance against a queue of
// expected digits pushed when each tick is driven.
module tb_game_countdown;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_in = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    game_countdown_if b60 ();
    game_countdown_if b10 ();
    game_countdown_if b3 ();

    assign b60.tick_in = tick_in;  assign b60.start = start;  assign b60.pause = pause;
    assign b10.tick_in = tick_in;  assign b10.start = start;  assign b10.pause = pause;
    assign b3.tick_in  = tick_in;  assign b3.start  = start;  assign b3.pause  = pause;

    game_countdown #(.START_SEC(60)) u60 (.clk_in(clk), .reset(rst_n), .bus(b60));
    game_countdown #(.START_SEC(10)) u10 (.clk_in(clk), .reset(rst_n), .bus(b10));
    game_countdown #(.START_SEC(3))  u3  (.clk_in(clk), .reset(rst_n), .bus(b3));

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; tick_in = 1'b0; start = 1'b0; pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p);
        @(negedge clk);
        start = s; pause = p;
        @(negedge clk);
        start = 1'b0; pause = 1'b0;
    endtask

    // One tick_in high/low cycle. cmd bit0=start, bit1=pause, driven so the
    // FSM samples them in the same cycle tick_out is high.
    task automatic do_tick(input int cmd, output int first_hi, output int width);
        first_hi = 0; width = 0;
        @(negedge clk);
        tick_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (b60.tick_out) begin
                width++;
                if (first_hi == 0) first_hi = i;
            end
            if (i == 3) begin start = cmd[0]; pause = cmd[1]; end
            if (i == 4) begin start = 1'b0; pause = 1'b0; tick_in = 1'b0; end
        end
    endtask

    task automatic ticks(input int n);
        int fh, w;
        for (int i = 0; i < n; i++) do_tick(0, fh, w);
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({b60.sec_tens, b60.sec_ones, b60.running, b60.time_up, b60.tick_out} !== {8'h60, 3'b000}) begin
            errors++;
            $display("FAIL reset60 got %h/%h r%b t%b k%b want 6/0 r0 t0 k0",
                     b60.sec_tens, b60.sec_ones, b60.running, b60.time_up, b60.tick_out);
        end
        checks++;
        if ({b10.sec_tens, b10.sec_ones, b3.sec_tens, b3.sec_ones} !== 16'h1003) begin
            errors++;
            $display("FAIL reset_small got %h%h %h%h want 10 03",
                     b10.sec_tens, b10.sec_ones, b3.sec_tens, b3.sec_ones);
        end
        exp = 8'h60;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
            checks++;
            if ({b60.sec_tens, b60.sec_ones} !== exp || b60.tick_out !== 1'b0 || b60.running !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got %h%h k%b r%b want 60 k0 r0",
                         b60.sec_tens, b60.sec_ones, b60.tick_out, b60.running);
            end
        end
        tick_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_countdown();
        int fh, w;
        logic [7:0] e;
        do_reset();
        pulse(1'b1, 1'b0);
        checks++;
        if (b60.running !== 1'b1 || {b60.sec_tens, b60.sec_ones} !== 8'h60) begin
            errors++;
            $display("FAIL start_run got r%b %h%h want r1 60", b60.running, b60.sec_tens, b60.sec_ones);
        end
        sb.push_back(8'h59); sb.push_back(8'h58); sb.push_back(8'h57);
        for (int i = 0; i < 3; i++) begin
            do_tick(0, fh, w);
            e = sb.pop_front();
            checks++;
            if ({b60.sec_tens, b60.sec_ones} !== e) begin
                errors++;
                $display("FAIL count got %h%h want %h", b60.sec_tens, b60.sec_ones, e);
            end
            checks++;
            if (fh != 3 || w != 1) begin
                errors++;
                $display("FAIL tick_shape got lat %0d width %0d want lat 3 width 1", fh, w);
            end
        end
    endtask

    task automatic test_borrow_done();
        logic [7:0] e;
        do_reset();
        pulse(1'b1, 1'b0);
        sb.push_back(8'h09); sb.push_back(8'h02);
        ticks(1);
        e = sb.pop_front();
        checks++;
        if ({b10.sec_tens, b10.sec_ones} !== e) begin
            errors++;
            $display("FAIL borrow got %h%h want %h", b10.sec_tens, b10.sec_ones, e);
        end
        e = sb.pop_front();
        checks++;
        if ({b3.sec_tens, b3.sec_ones} !== e) begin
            errors++;
            $display("FAIL three_first got %h%h want %h", b3.sec_tens, b3.sec_ones, e);
        end
        sb.push_back(8'h01);
        ticks(1);
        e = sb.pop_front();
        checks++;
        if ({b3.sec_tens, b3.sec_ones} !== e || b3.time_up !== 1'b0) begin
            errors++;
            $display("FAIL three_second got %h%h t%b want %h t0", b3.sec_tens, b3.sec_ones, b3.time_up, e);
        end
        sb.push_back(8'h00);
        ticks(1);
        e = sb.pop_front();
        checks++;
        if ({b3.sec_tens, b3.sec_ones} !== e || b3.time_up !== 1'b1 || b3.running !== 1'b0) begin
            errors++;
            $display("FAIL done got %h%h t%b r%b want %h t1 r0",
                     b3.sec_tens, b3.sec_ones, b3.time_up, b3.running, e);
        end
        sb.push_back(8'h00); sb.push_back(8'h05);
        ticks(2);
        e = sb.pop_front();
        checks++;
        if ({b3.sec_tens, b3.sec_ones} !== e || b3.time_up !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got %h%h t%b want %h t1", b3.sec_tens, b3.sec_ones, b3.time_up, e);
        end
        e = sb.pop_front();
        checks++;
        if ({b10.sec_tens, b10.sec_ones} !== e || b10.running !== 1'b1) begin
            errors++;
            $display("FAIL ten_run got %h%h r%b want %h r1", b10.sec_tens, b10.sec_ones, b10.running, e);
        end
    endtask

    task automatic test_pause();
        int fh, w;
        logic [7:0] e;
        do_reset();
        pulse(1'b1, 1'b0);
        ticks(15);
        pulse(1'b0, 1'b1);
        checks++;
        if (b60.running !== 1'b0 || {b60.sec_tens, b60.sec_ones} !== 8'h45) begin
            errors++;
            $display("FAIL pause_enter got r%b %h%h want r0 45", b60.running, b60.sec_tens, b60.sec_ones);
        end
        sb.push_back(8'h45);
        ticks(5);
        e = sb.pop_front();
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== e) begin
            errors++;
            $display("FAIL pause_hold got %h%h want %h", b60.sec_tens, b60.sec_ones, e);
        end
        pulse(1'b0, 1'b1);
        sb.push_back(8'h44);
        ticks(1);
        e = sb.pop_front();
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== e || b60.running !== 1'b1) begin
            errors++;
            $display("FAIL resume got %h%h r%b want %h r1", b60.sec_tens, b60.sec_ones, b60.running, e);
        end
        sb.push_back(8'h43);
        do_tick(2, fh, w);
        e = sb.pop_front();
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== e || b60.running !== 1'b0) begin
            errors++;
            $display("FAIL pause_tick got %h%h r%b want %h r0", b60.sec_tens, b60.sec_ones, b60.running, e);
        end
    endtask

    task automatic test_start_priority();
        int fh, w;
        logic [7:0] e;
        do_reset();
        pulse(1'b1, 1'b0);
        ticks(40);
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== 8'h20) begin
            errors++;
            $display("FAIL reach20 got %h%h want 20", b60.sec_tens, b60.sec_ones);
        end
        sb.push_back(8'h60);
        do_tick(1, fh, w);
        e = sb.pop_front();
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== e || b60.running !== 1'b1) begin
            errors++;
            $display("FAIL start_tick got %h%h r%b want %h r1", b60.sec_tens, b60.sec_ones, b60.running, e);
        end
        ticks(1);
        pulse(1'b1, 1'b1);
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== 8'h60 || b60.running !== 1'b1) begin
            errors++;
            $display("FAIL start_pause got %h%h r%b want 60 r1", b60.sec_tens, b60.sec_ones, b60.running);
        end
        ticks(3);
        checks++;
        if (b3.time_up !== 1'b1) begin
            errors++;
            $display("FAIL pre_restart got t%b want t1", b3.time_up);
        end
        pulse(1'b1, 1'b0);
        checks++;
        if ({b3.sec_tens, b3.sec_ones} !== 8'h03 || b3.running !== 1'b1 || b3.time_up !== 1'b0 ||
            {b60.sec_tens, b60.sec_ones} !== 8'h60) begin
            errors++;
            $display("FAIL restart got %h%h r%b t%b / %h%h want 03 r1 t0 / 60",
                     b3.sec_tens, b3.sec_ones, b3.running, b3.time_up, b60.sec_tens, b60.sec_ones);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        pulse(1'b1, 1'b0);
        ticks(23);
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== 8'h37) begin
            errors++;
            $display("FAIL reach37 got %h%h want 37", b60.sec_tens, b60.sec_ones);
        end
        @(negedge clk);
        tick_in = 1'b1;
        n = 0;
        while (b60.tick_out !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (b60.tick_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait got no tick_out within %0d cycles want pulse", n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b60.sec_tens, b60.sec_ones} !== 8'h60 || b60.running !== 1'b0 || b60.tick_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %h%h r%b k%b want 60 r0 k0",
                     b60.sec_tens, b60.sec_ones, b60.running, b60.tick_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b60.tick_out) n++;
        end
        checks++;
        if (n != 1 || {b60.sec_tens, b60.sec_ones} !== 8'h60 || b60.running !== 1'b0) begin
            errors++;
            $display("FAIL spurious got %0d pulses %h%h r%b want 1 pulse 60 r0",
                     n, b60.sec_tens, b60.sec_ones, b60.running);
        end
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow_done();
        test_pause();
        test_start_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
